// File: rtl/pipe_mips32.sv
// 5-stage MIPS-like core (IF/ID/EX/MEM/WB), write-back 4 cycles after fetch, no external backpressure;
// full forwarding, branches resolved in EX (2-bubble penalty). MUL is enabled by defining MIPS_MUL_EN.
module pipe_mips32 #(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic halted
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic        hlt_seen;

  logic        ifid_vld;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc;

  logic        idex_vld;
  logic [5:0]  idex_op;
  logic [4:0]  idex_rs;
  logic [4:0]  idex_rt;
  logic [4:0]  idex_dst;
  logic        idex_wr;
  logic [31:0] idex_a;
  logic [31:0] idex_b;
  logic [31:0] idex_imm;
  logic [31:0] idex_pc;

  logic        exmem_vld;
  logic [5:0]  exmem_op;
  logic [4:0]  exmem_dst;
  logic        exmem_wr;
  logic [31:0] exmem_alu;
  logic [31:0] exmem_b;

  logic        memwb_vld;
  logic [5:0]  memwb_op;
  logic [4:0]  memwb_dst;
  logic        memwb_wr;
  logic [31:0] memwb_res;

  assign halted = HALTED;

  // ID: decode and register read
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm;
  logic [4:0]  id_dst;
  logic        id_wr;
  logic        id_hlt;
  logic        wb_we;
  logic [31:0] id_a, id_b;

  assign id_op  = ifid_ir[31:26];
  assign id_rs  = ifid_ir[25:21];
  assign id_rt  = ifid_ir[20:16];
  assign id_rd  = ifid_ir[15:11];
  assign id_imm = {{16{ifid_ir[15]}}, ifid_ir[15:0]};
  assign id_hlt = ifid_vld && (id_op == OP_HLT);

  always_comb begin
    id_dst = 5'd0;
    id_wr  = 1'b0;
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        id_dst = id_rd;
        id_wr  = 1'b1;
      end
`ifdef MIPS_MUL_EN
      OP_MUL: begin
        id_dst = id_rd;
        id_wr  = 1'b1;
      end
`endif
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
        id_dst = id_rt;
        id_wr  = 1'b1;
      end
      default: begin
        id_dst = 5'd0;
        id_wr  = 1'b0;
      end
    endcase
    // R0 writes are dropped here so they are never forwarded either
    if (id_dst == 5'd0 || !ifid_vld)
      id_wr = 1'b0;
  end

  assign wb_we = memwb_vld && memwb_wr && !HALTED;
  assign id_a  = (wb_we && memwb_dst == id_rs) ? memwb_res : Reg[id_rs];
  assign id_b  = (wb_we && memwb_dst == id_rt) ? memwb_res : Reg[id_rt];

  // EX: operand forwarding, ALU, branch resolution
  logic [31:0] ex_a, ex_b, ex_alu, ex_target;
  logic        ex_taken;
  logic        fwd_mem_ok;

  assign fwd_mem_ok = exmem_vld && exmem_wr && (exmem_op != OP_LW);

  always_comb begin
    ex_a = idex_a;
    ex_b = idex_b;
    if (memwb_vld && memwb_wr && memwb_dst == idex_rs) ex_a = memwb_res;
    if (memwb_vld && memwb_wr && memwb_dst == idex_rt) ex_b = memwb_res;
    // A load still in MEM has no data yet; consumers see the older value
    if (fwd_mem_ok && exmem_dst == idex_rs) ex_a = exmem_alu;
    if (fwd_mem_ok && exmem_dst == idex_rt) ex_b = exmem_alu;
  end

  always_comb begin
    ex_alu = 32'd0;
    case (idex_op)
      OP_ADD:                ex_alu = ex_a + ex_b;
      OP_SUB:                ex_alu = ex_a - ex_b;
      OP_AND:                ex_alu = ex_a & ex_b;
      OP_OR:                 ex_alu = ex_a | ex_b;
      OP_SLT:                ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
`ifdef MIPS_MUL_EN
      OP_MUL:                ex_alu = ex_a * ex_b;
`endif
      OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + idex_imm;
      OP_SUBI:               ex_alu = ex_a - idex_imm;
      OP_SLTI:               ex_alu = {31'd0, $signed(ex_a) < $signed(idex_imm)};
      default:               ex_alu = 32'd0;
    endcase
  end

  assign ex_taken  = idex_vld && (((idex_op == OP_BNEQZ) && (ex_a != 32'd0)) ||
                                  ((idex_op == OP_BEQZ)  && (ex_a == 32'd0)));
  assign ex_target = idex_pc + 32'd1 + idex_imm;

  logic [31:0] mem_rdata;
  assign mem_rdata = Mem[exmem_alu[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      hlt_seen     <= 1'b0;
      ifid_vld     <= 1'b0;
      ifid_ir      <= 32'd0;
      ifid_pc      <= 32'd0;
      idex_vld     <= 1'b0;
      idex_op      <= 6'd0;
      idex_rs      <= 5'd0;
      idex_rt      <= 5'd0;
      idex_dst     <= 5'd0;
      idex_wr      <= 1'b0;
      idex_a       <= 32'd0;
      idex_b       <= 32'd0;
      idex_imm     <= 32'd0;
      idex_pc      <= 32'd0;
      exmem_vld    <= 1'b0;
      exmem_op     <= 6'd0;
      exmem_dst    <= 5'd0;
      exmem_wr     <= 1'b0;
      exmem_alu    <= 32'd0;
      exmem_b      <= 32'd0;
      memwb_vld    <= 1'b0;
      memwb_op     <= 6'd0;
      memwb_dst    <= 5'd0;
      memwb_wr     <= 1'b0;
      memwb_res    <= 32'd0;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= ex_taken;
      if (memwb_vld && memwb_op == OP_HLT)
        HALTED <= 1'b1;

      if (ex_taken) begin
        PC       <= ex_target;
        ifid_vld <= 1'b0;
      end else if (hlt_seen || id_hlt) begin
        ifid_vld <= 1'b0;
      end else begin
        ifid_vld <= 1'b1;
        ifid_ir  <= Mem[PC[AW-1:0]];
        ifid_pc  <= PC;
        PC       <= PC + 32'd1;
      end
      // A HLT in the shadow of a taken branch is squashed and must not stop fetch
      if (id_hlt && !ex_taken)
        hlt_seen <= 1'b1;

      idex_vld <= ifid_vld && !ex_taken;
      idex_op  <= id_op;
      idex_rs  <= id_rs;
      idex_rt  <= id_rt;
      idex_dst <= id_dst;
      idex_wr  <= id_wr && !ex_taken;
      idex_a   <= id_a;
      idex_b   <= id_b;
      idex_imm <= id_imm;
      idex_pc  <= ifid_pc;

      exmem_vld <= idex_vld;
      exmem_op  <= idex_op;
      exmem_dst <= idex_dst;
      exmem_wr  <= idex_wr && idex_vld;
      exmem_alu <= ex_alu;
      exmem_b   <= ex_b;

      memwb_vld <= exmem_vld;
      memwb_op  <= exmem_op;
      memwb_dst <= exmem_dst;
      memwb_wr  <= exmem_wr && exmem_vld;
      memwb_res <= (exmem_op == OP_LW) ? mem_rdata : exmem_alu;
    end
  end

  // Architectural storage survives reset; bubbles keep it safe while rst is held
  always_ff @(posedge clk) begin
    if (wb_we)
      Reg[memwb_dst] <= memwb_res;
    if (exmem_vld && exmem_op == OP_SW && !HALTED)
      Mem[exmem_alu[AW-1:0]] <= exmem_b;
  end

endmodule

// File: tb/tb_pipe_mips32.sv
// Directed program bench for pipe_mips32 with backdoor preload of Reg/Mem.
module tb_pipe_mips32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halted;
  int   tests = 0;
  int   fails = 0;
  int   tb_cnt = 0;

  always #5 clk = ~clk;

  pipe_mips32 #(.MEM_WORDS(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .halted (halted)
  );

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    for (int i = 0; i < 64; i++) dut.Mem[i] = 32'd0;
  endtask

  task automatic run(input int n);
    rst = 1'b0;
    tb_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (dut.TAKEN_BRANCH === 1'b1) tb_cnt++;
    end
  endtask

  initial begin
    logic [31:0] exp_mul;

    // reset state
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    check("rst_bubble", {29'd0, dut.ifid_vld, dut.idex_vld, dut.exmem_vld}, 32'd0);

    // load/store with one-instruction spacing
    preload();
    dut.Mem[120] = 32'd85;
    dut.Mem[0] = ri(6'd10, 5'd1, 5'd0, 16'd120);
    dut.Mem[1] = rr(6'd3, 5'd3, 5'd3, 5'd3);
    dut.Mem[2] = ri(6'd8, 5'd2, 5'd1, 16'd0);
    dut.Mem[3] = rr(6'd3, 5'd3, 5'd3, 5'd3);
    dut.Mem[4] = ri(6'd10, 5'd2, 5'd2, 16'd45);
    dut.Mem[5] = rr(6'd3, 5'd3, 5'd3, 5'd3);
    dut.Mem[6] = ri(6'd9, 5'd2, 5'd1, 16'd1);
    dut.Mem[7] = {6'd63, 26'd0};
    run(40);
    check("ls_mem120", dut.Mem[120], 32'd85);
    check("ls_mem121", dut.Mem[121], 32'd130);
    check("ls_r1", dut.Reg[1], 32'd120);
    check("ls_r2", dut.Reg[2], 32'd130);
    check("ls_halted", {31'd0, halted}, 32'd1);

    // back-to-back forwarding
    preload();
    dut.Mem[0] = ri(6'd10, 5'd1, 5'd0, 16'd10);
    dut.Mem[1] = rr(6'd0, 5'd2, 5'd1, 5'd1);
    dut.Mem[2] = rr(6'd1, 5'd3, 5'd2, 5'd1);
    dut.Mem[3] = {6'd63, 26'd0};
    run(30);
    check("fw_r1", dut.Reg[1], 32'd10);
    check("fw_r2", dut.Reg[2], 32'd20);
    check("fw_r3", dut.Reg[3], 32'd10);

    // taken branch skips two, untaken falls through
    preload();
    dut.Mem[0] = ri(6'd14, 5'd0, 5'd0, 16'd2);
    dut.Mem[1] = ri(6'd10, 5'd5, 5'd0, 16'd7);
    dut.Mem[2] = ri(6'd10, 5'd7, 5'd0, 16'd9);
    dut.Mem[3] = ri(6'd13, 5'd0, 5'd0, 16'd5);
    dut.Mem[4] = ri(6'd10, 5'd8, 5'd0, 16'd11);
    dut.Mem[5] = {6'd63, 26'd0};
    run(30);
    check("br_r5", dut.Reg[5], 32'd5);
    check("br_r7", dut.Reg[7], 32'd7);
    check("br_r8", dut.Reg[8], 32'd11);
    check("br_pulses", tb_cnt, 32'd1);
    check("br_halted", {31'd0, halted}, 32'd1);

    // nothing younger than HLT takes effect
    preload();
    dut.Mem[50] = 32'hdead;
    dut.Mem[0] = {6'd63, 26'd0};
    dut.Mem[1] = ri(6'd10, 5'd6, 5'd0, 16'd99);
    dut.Mem[2] = ri(6'd9, 5'd6, 5'd0, 16'd50);
    run(20);
    check("hlt_r6", dut.Reg[6], 32'd6);
    check("hlt_mem50", dut.Mem[50], 32'hdead);
    check("hlt_halted", {31'd0, halted}, 32'd1);
    check("hlt_pc", dut.PC, 32'd1);
    run(10);
    check("hlt_pc_frozen", dut.PC, 32'd1);

    // asynchronous reset in mid-program
    preload();
    dut.Mem[200] = 32'd1234;
    dut.Mem[0] = ri(6'd10, 5'd10, 5'd0, 16'd77);
    dut.Mem[1] = ri(6'd10, 5'd11, 5'd0, 16'd88);
    dut.Mem[2] = ri(6'd9, 5'd10, 5'd0, 16'd200);
    dut.Mem[3] = {6'd63, 26'd0};
    run(3);
    check("mr_pc_before", dut.PC, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("mr_pc_async", dut.PC, 32'd0);
    check("mr_halted_async", {31'd0, halted}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("mr_r10", dut.Reg[10], 32'd10);
    check("mr_r11", dut.Reg[11], 32'd11);
    check("mr_mem200", dut.Mem[200], 32'd1234);
    check("mr_mem120", dut.Mem[120], 32'd85);
    run(30);
    check("mr_rerun_r10", dut.Reg[10], 32'd77);
    check("mr_rerun_mem200", dut.Mem[200], 32'd77);

    // MUL, present or absent depending on build
    preload();
    dut.Reg[2] = 32'd6;
    dut.Reg[3] = 32'd7;
    dut.Mem[0] = rr(6'd5, 5'd4, 5'd2, 5'd3);
    dut.Mem[1] = {6'd63, 26'd0};
`ifdef MIPS_MUL_EN
    exp_mul = 32'd42;
`else
    exp_mul = 32'd4;
`endif
    run(20);
    check("mul_r4", dut.Reg[4], exp_mul);
    check("mul_halted", {31'd0, halted}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
